// File: rtl/usb_stream_pkg.sv
// Shared types and constants for the USB audio stream arbiter.
package usb_stream_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        B2    = 3'd2,
        B1    = 3'd3,
        B0    = 3'd4,
        FLUSH = 3'd5
    } state_t;

    localparam logic [5:0] HDR_TAG  = 6'b101000;
    localparam logic [1:0] EP6_ADDR = 2'b10;
    localparam int         CH_COUNT = 4;
    localparam int         SAMPLE_W = 24;

    // Header byte: fixed tag in the top six bits, channel number below.
    function automatic logic [7:0] hdr_byte(input logic [1:0] ch);
        return {HDR_TAG, ch};
    endfunction

endpackage

// File: rtl/usb_stream_arbiter_rr.sv
// Four-way round-robin arbiter; the pointer moves past the winner only
// when the grant is actually taken.
module rr_arbiter4 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_vld_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] cand_s;

    // Search from the pointer upwards; scanning offsets high-to-low lets the
    // lowest offset (highest priority) win last.
    always_comb begin
        gnt_idx_o = ptr_q;
        gnt_vld_o = 1'b0;
        cand_s    = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand_s = ptr_q + 2'(i);
            if (req_i[cand_s]) begin
                gnt_idx_o = cand_s;
                gnt_vld_o = 1'b1;
            end else begin
                gnt_vld_o = gnt_vld_o;
            end
        end
    end

    // Next pointer: one past the accepted channel.
    always_comb begin
        if (accept_i && gnt_vld_o) begin
            ptr_d = gnt_idx_o + 2'b01;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register, back to channel 0 on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 2'b00;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/usb_stream_arbiter.sv
// Packs four 24-bit I2S sample streams into FX2 EP6 slave-FIFO writes:
// a header byte plus three data bytes per sample, flushing short packets
// with PKTEND after an idle timeout or when streaming stops.
module usb_stream_arbiter
    import usb_stream_pkg::*;
#(
    parameter int PKT_BYTES = 512,
    parameter int TIMEOUT   = 4096
) (
    input  logic        USBCLK_IN,
    input  logic        RESET_IN,
    input  logic        STMEN,
    input  logic [3:0]  REQ,
    input  logic [95:0] SAMPLE,
    output logic [3:0]  ACK,
    input  logic        FLAGB,
    output logic        SLWR,
    output logic        SLRD,
    output logic        SLOE,
    output logic        PKTEND,
    output logic [1:0]  FIFOADR,
    output logic [7:0]  USBDB,
    output logic [15:0] DROPPED
);

    localparam int BCW = $clog2(PKT_BYTES);
    localparam int TW  = $clog2(TIMEOUT) + 1;
    localparam logic [BCW-1:0] BC_LAST  = BCW'(PKT_BYTES - 1);
    localparam logic [BCW-1:0] BC_ZERO  = BCW'(0);
    localparam logic [BCW-1:0] BC_ONE   = BCW'(1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  TMO_ZERO = TW'(0);
    localparam logic [TW-1:0]  TMO_ONE  = TW'(1);

    state_t                state_q, state_d;
    logic [3:0]            ack_q, ack_d;
    logic                  slwr_q, slwr_d;
    logic                  pktend_q, pktend_d;
    logic [7:0]            usbdb_q, usbdb_d;
    logic [15:0]           dropped_q, dropped_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [1:0]            chan_q, chan_d;
    logic                  slrd_q, sloe_q;
    logic [1:0]            fifoadr_q;

    logic [1:0]            gnt_idx_s;
    logic                  gnt_vld_s;
    logic                  accept_s;
    logic [7:0]            cur_byte_s;
    state_t                nxt_byte_state_s;

    rr_arbiter4 u_arb (
        .clk_i     (USBCLK_IN),
        .rst_i     (RESET_IN),
        .req_i     (REQ),
        .accept_i  (accept_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    // Byte presented by the current byte state and the state that follows it.
    always_comb begin
        cur_byte_s       = 8'h00;
        nxt_byte_state_s = IDLE;
        case (state_q)
            HDR: begin
                cur_byte_s       = hdr_byte(chan_q);
                nxt_byte_state_s = B2;
            end
            B2: begin
                cur_byte_s       = sample_q[23:16];
                nxt_byte_state_s = B1;
            end
            B1: begin
                cur_byte_s       = sample_q[15:8];
                nxt_byte_state_s = B0;
            end
            B0: begin
                cur_byte_s       = sample_q[7:0];
                nxt_byte_state_s = IDLE;
            end
            default: begin
                cur_byte_s       = 8'h00;
                nxt_byte_state_s = IDLE;
            end
        endcase
    end

    // Main FSM: grant/capture in IDLE, one FIFO write per byte state when
    // the FIFO has room, flush of a partial packet otherwise.
    always_comb begin
        state_d  = state_q;
        ack_d    = 4'b0000;
        slwr_d   = 1'b1;
        pktend_d = 1'b1;
        usbdb_d  = usbdb_q;
        bcnt_d   = bcnt_q;
        tmo_d    = tmo_q;
        sample_d = sample_q;
        chan_d   = chan_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (STMEN && gnt_vld_s) begin
                    accept_s = 1'b1;
                    ack_d    = 4'b0001 << gnt_idx_s;
                    chan_d   = gnt_idx_s;
                    tmo_d    = TMO_ZERO;
                    state_d  = HDR;
                    for (int k = 0; k < CH_COUNT; k++) begin
                        if (gnt_idx_s == 2'(k)) begin
                            sample_d = SAMPLE[k*SAMPLE_W +: SAMPLE_W];
                        end else begin
                            sample_d = sample_d;
                        end
                    end
                end else if (bcnt_q != BC_ZERO) begin
                    if (!STMEN || (tmo_q == TMO_LAST)) begin
                        state_d  = FLUSH;
                        pktend_d = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end else begin
                    tmo_d = TMO_ZERO;
                end
            end
            HDR, B2, B1, B0: begin
                usbdb_d = cur_byte_s;
                if (FLAGB) begin
                    slwr_d  = 1'b0;
                    bcnt_d  = (bcnt_q == BC_LAST) ? BC_ZERO : (bcnt_q + BC_ONE);
                    state_d = nxt_byte_state_s;
                end else begin
                    state_d = state_q;
                end
            end
            FLUSH: begin
                bcnt_d  = BC_ZERO;
                tmo_d   = TMO_ZERO;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating count of cycles with a pending request while streaming is off.
    always_comb begin
        if ((REQ != 4'b0000) && !STMEN && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end else begin
            dropped_d = dropped_q;
        end
    end

    // State and output registers.
    always_ff @(posedge USBCLK_IN) begin
        if (RESET_IN) begin
            state_q   <= IDLE;
            ack_q     <= 4'b0000;
            slwr_q    <= 1'b1;
            pktend_q  <= 1'b1;
            usbdb_q   <= 8'h00;
            dropped_q <= 16'h0000;
            bcnt_q    <= BC_ZERO;
            tmo_q     <= TMO_ZERO;
            sample_q  <= 24'h000000;
            chan_q    <= 2'b00;
            slrd_q    <= 1'b1;
            sloe_q    <= 1'b1;
            fifoadr_q <= EP6_ADDR;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            slwr_q    <= slwr_d;
            pktend_q  <= pktend_d;
            usbdb_q   <= usbdb_d;
            dropped_q <= dropped_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            sample_q  <= sample_d;
            chan_q    <= chan_d;
            slrd_q    <= 1'b1;
            sloe_q    <= 1'b1;
            fifoadr_q <= EP6_ADDR;
        end
    end

    assign ACK     = ack_q;
    assign SLWR    = slwr_q;
    assign SLRD    = slrd_q;
    assign SLOE    = sloe_q;
    assign PKTEND  = pktend_q;
    assign FIFOADR = fifoadr_q;
    assign USBDB   = usbdb_q;
    assign DROPPED = dropped_q;

endmodule

// File: doc/usb_stream_arbiter.md
USB_STREAM_ARBITER -- requirements
Module: usb_stream_arbiter

Interface
REQ-001 The block SHALL have parameter PKT_BYTES, default 512, meaning bytes per full USB packet; it SHALL be a multiple of 4.
REQ-002 The block SHALL have parameter TIMEOUT, default 4096, meaning idle USBCLK_IN cycles before a partial packet is flushed.
REQ-003 The block SHALL have port USBCLK_IN, input, 1 bit: the one clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET_IN, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port STMEN, input, 1 bit: stream enable; 1 = arbitrate and send.
REQ-006 The block SHALL have port REQ, input, 4 bits: per-channel sample-valid, held high until ACK; channels {I2S0-L, I2S0-R, I2S1-L, I2S1-R}.
REQ-007 The block SHALL have port SAMPLE, input, 96 bits: four 24-bit samples, channel k at bits [24k+23:24k].
REQ-008 The block SHALL have port ACK, output, 4 bits: one-cycle pulse when channel k's sample is captured.
REQ-009 The block SHALL have port FLAGB, input, 1 bit: FX2 EP6 full flag, active-low (0 = full).
REQ-010 The block SHALL have ports SLWR, SLRD, SLOE, PKTEND, output, 1 bit each: FX2 strobes, active-low.
REQ-011 The block SHALL have port FIFOADR, output, 2 bits: endpoint select, constant 2'b10 (EP6).
REQ-012 The block SHALL have port USBDB, output, 8 bits: FIFO write data.
REQ-013 The block SHALL have port DROPPED, output, 16 bits: count of cycles in which REQ was pending while STMEN=0. It saturates at 16'hFFFF.

Function
REQ-014 SLRD and SLOE SHALL be held at 1 permanently; all outputs SHALL be registered.
REQ-015 The state machine SHALL have the states IDLE, HDR, B2, B1, B0 and FLUSH.
REQ-016 In IDLE, with STMEN=1 and REQ≠0, the round-robin grant k SHALL be chosen; the next cycle SHALL pulse ACK[k], capture SAMPLE[k] and go to HDR.
REQ-017 Round-robin priority SHALL start at channel 0 after reset, and SHALL become k+1 mod 4 after a grant to k; with all four requesting, the grant order SHALL be 0,1,2,3,0.
REQ-018 Per sample, the bytes SHALL be sent in the order HDR = {6'b101000, k[1:0]}, then bits [23:16], [15:8] and [7:0] (MSB first).
REQ-019 In each byte state, SLWR SHALL be driven to 0 with USBDB valid for exactly one cycle per byte, and only when FLAGB=1 was sampled at the preceding edge.
REQ-020 Otherwise the block SHALL stall in the current state with SLWR=1 and USBDB held.
REQ-021 Latency SHALL be: REQ seen at edge n → ACK during cycle n+1 → HDR write cycle n+2 when not full; minimum 5 cycles per sample.
REQ-022 The packet byte counter SHALL increment on each write and wrap to 0 at PKT_BYTES; a sample never straddles packets.
REQ-023 The FX2 auto-commits full packets, so PKTEND SHALL NOT be pulsed at a wrap.
REQ-024 From IDLE, if the byte counter ≠ 0 and either no grant occurred for TIMEOUT consecutive cycles or STMEN=0, the block SHALL go to FLUSH.
REQ-025 FLUSH SHALL pulse PKTEND=0 for one cycle, clear the counter and the timeout, and return to IDLE.
REQ-026 PKTEND SHALL never be issued with a byte counter of 0; zero-length packets are forbidden.
REQ-027 STMEN falling mid-sample SHALL NOT abort it: the remaining bytes complete, then FLUSH follows if the counter ≠ 0.
REQ-028 A REQ rising during FLUSH or the byte states SHALL wait; no ACK is given outside the IDLE→HDR transition.
REQ-029 A new grant in IDLE SHALL reset the timeout counter, and a grant SHALL take precedence over a timeout flush on the same cycle.

Reset
REQ-030 On RESET_IN=1 at an edge, the state SHALL be IDLE and ACK SHALL be 0.
REQ-031 On reset, SLWR, PKTEND, SLRD and SLOE SHALL be 1, USBDB SHALL be 8'h00, FIFOADR SHALL be 2'b10 and DROPPED SHALL be 0.
REQ-032 On reset, the byte and timeout counters SHALL be 0 and the priority SHALL be channel 0.
REQ-033 Reset mid-sample SHALL discard the partial sample with no PKTEND.

Structure
REQ-034 The shared package usb_stream_pkg SHALL hold: the state enum, HDR_TAG (6'b101000), EP6_ADDR (2'b10), CH_COUNT (4) and SAMPLE_W (24).
REQ-035 The one sub-module SHALL be rr_arbiter4: a 4-way round-robin grant with a pointer update on accept.

Verification
REQ-036 Reset, then REQ=4'b0001 with SAMPLE[23:0]=24'h123456 and FLAGB=1 → ACK[0] for one cycle, then USBDB A0,12,34,56 on 4 consecutive SLWR=0 cycles, with PKTEND=1 throughout.
REQ-037 REQ=4'b1111 held for 8 grants → ACK order 0,1,2,3,0,1,2,3, with headers A0,A1,A2,A3 repeating.
REQ-038 FLAGB=0 for 10 cycles after the 12 byte → SLWR=1 and USBDB=34 stable for those cycles, then 34,56 are written; no byte is lost or duplicated.
REQ-039 Send 128 samples (512 bytes), then 1 more, then idle with TIMEOUT=16 → no PKTEND at 512; exactly one PKTEND pulse 16 cycles after the last write; counter then 0.
REQ-040 STMEN dropped during the B2 state → B1 and B0 still complete, PKTEND follows, and no further ACK is given.
REQ-041 REQ held with STMEN=0 for 5 cycles → DROPPED=5 and no SLWR activity.
REQ-042 RESET_IN asserted during B1 → next cycle SLWR=1, no PKTEND, counter=0, and the priority pointer is back at channel 0.
